// File: rtl/fft_pkg.sv
// Shared FFT constants: default widths, Q-format unity, quadrant map.
// Also holds the rounding helper used to build the twiddle tables.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int TW_WIDTH_DEF   = 16;

  localparam real PI = 3.14159265358979323846;

  // Exponent multiplier per quadrant q of the sub-transform.
  localparam logic [1:0] QMAP [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  // Q1.(tw-2) value of +1.0.
  function automatic int tw_one(input int tw);
    return 1 << (tw - 2);
  endfunction

  function automatic int round_nearest(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle table W_M^e = c + j*d for e in [0, 3M/4).
// Entries are built at elaboration and rounded to nearest.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int TW_WIDTH = TW_WIDTH_DEF,
  parameter int M        = 16
) (
  input  logic [$clog2(M)-1:0]       i_idx,
  output logic signed [TW_WIDTH-1:0] o_c,
  output logic signed [TW_WIDTH-1:0] o_d
);

  localparam int  NB  = $clog2(M);
  localparam int  E   = 3 * M / 4;
  localparam real ONE = real'(tw_one(TW_WIDTH));

  logic signed [TW_WIDTH-1:0] w_c_tab [E];
  logic signed [TW_WIDTH-1:0] w_d_tab [E];

  for (genvar k = 0; k < E; k++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(k) / real'(M);
    assign w_c_tab[k] = TW_WIDTH'(round_nearest(ONE * $cos(ANG)));
    assign w_d_tab[k] = TW_WIDTH'(round_nearest(-ONE * $sin(ANG)));
  end

  // Select the table entry for the requested exponent.
  always_comb begin
    o_c = '0;
    o_d = '0;
    for (int k = 0; k < E; k++) begin
      if (i_idx == NB'(k)) begin
        o_c = w_c_tab[k];
        o_d = w_d_tab[k];
      end
    end
  end

endmodule

// File: rtl/fft_twiddle_mult.sv
// Radix-2^2 inter-stage twiddle multiplier, 3-cycle pipeline.
// Counts valid samples to derive the twiddle exponent per sample.
module fft_twiddle_mult
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_WIDTH   = TW_WIDTH_DEF,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_val,
  input  logic signed [DATA_WIDTH-1:0] in_re,
  input  logic signed [DATA_WIDTH-1:0] in_im,
  output logic                         out_val,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im
);

  localparam int M  = N_POINTS >> (2 * STAGE);
  localparam int NB = (M >= 4) ? $clog2(M) : 2;
  localparam int PW = DATA_WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam int SH = TW_WIDTH - 2;

  localparam logic signed [SW-1:0] RND =
    SW'(1) << (TW_WIDTH - 3);
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (M < 4 || (M & (M - 1)) != 0) begin : g_bad_m
    $error("fft_twiddle_mult: sub-transform length M must be a power of 2 and >= 4");
  end

  function automatic logic signed [DATA_WIDTH-1:0] sat(
    input logic signed [SW-1:0] x
  );
    if (x > MAXV) return MAXV[DATA_WIDTH-1:0];
    if (x < MINV) return MINV[DATA_WIDTH-1:0];
    return x[DATA_WIDTH-1:0];
  endfunction

  logic [NB-1:0] r_n;
  logic [1:0]    w_q;
  logic [NB-1:0] w_m;
  logic [NB-1:0] w_e;

  logic signed [TW_WIDTH-1:0] w_c;
  logic signed [TW_WIDTH-1:0] w_d;

  logic                         r_p1_val;
  logic signed [DATA_WIDTH-1:0] r_p1_re;
  logic signed [DATA_WIDTH-1:0] r_p1_im;
  logic signed [TW_WIDTH-1:0]   r_p1_c;
  logic signed [TW_WIDTH-1:0]   r_p1_d;

  logic                 r_p2_val;
  logic signed [PW-1:0] r_p2_ac;
  logic signed [PW-1:0] r_p2_bd;
  logic signed [PW-1:0] r_p2_ad;
  logic signed [PW-1:0] r_p2_bc;

  logic signed [SW-1:0] w_re_sum;
  logic signed [SW-1:0] w_im_sum;
  logic signed [SW-1:0] w_re_shf;
  logic signed [SW-1:0] w_im_shf;

  logic                         r_out_val;
  logic signed [DATA_WIDTH-1:0] r_out_re;
  logic signed [DATA_WIDTH-1:0] r_out_im;

  assign w_q = r_n[NB-1:NB-2];
  assign w_m = r_n & NB'(M / 4 - 1);
  assign w_e = w_m * NB'(QMAP[w_q]);

  fft_twiddle_rom #(
    .TW_WIDTH (TW_WIDTH),
    .M        (M)
  ) u_rom (
    .i_idx (w_e),
    .o_c   (w_c),
    .o_d   (w_d)
  );

  // Sample index within the sub-transform; wraps naturally at M.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n <= '0;
    end else if (en && in_val) begin
      r_n <= r_n + 1'b1;
    end
  end

  // P1: capture sample and its twiddle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1_val <= 1'b0;
      r_p1_re  <= '0;
      r_p1_im  <= '0;
      r_p1_c   <= '0;
      r_p1_d   <= '0;
    end else if (en) begin
      r_p1_val <= in_val;
      r_p1_re  <= in_re;
      r_p1_im  <= in_im;
      r_p1_c   <= w_c;
      r_p1_d   <= w_d;
    end
  end

  // P2: the four partial products at full precision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p2_val <= 1'b0;
      r_p2_ac  <= '0;
      r_p2_bd  <= '0;
      r_p2_ad  <= '0;
      r_p2_bc  <= '0;
    end else if (en) begin
      r_p2_val <= r_p1_val;
      r_p2_ac  <= PW'(r_p1_re) * PW'(r_p1_c);
      r_p2_bd  <= PW'(r_p1_im) * PW'(r_p1_d);
      r_p2_ad  <= PW'(r_p1_re) * PW'(r_p1_d);
      r_p2_bc  <= PW'(r_p1_im) * PW'(r_p1_c);
    end
  end

  assign w_re_sum = SW'(r_p2_ac) - SW'(r_p2_bd);
  assign w_im_sum = SW'(r_p2_ad) + SW'(r_p2_bc);
  assign w_re_shf = (w_re_sum + RND) >>> SH;
  assign w_im_shf = (w_im_sum + RND) >>> SH;

  // P3: round, rescale and saturate into the output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_val <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else if (en) begin
      r_out_val <= r_p2_val;
      r_out_re  <= sat(w_re_shf);
      r_out_im  <= sat(w_im_shf);
    end
  end

  assign out_val = r_out_val;
  assign out_re  = r_out_re;
  assign out_im  = r_out_im;

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Bench for fft_twiddle_mult: N=16/STAGE=0 exact model and
// N=64/STAGE=1 floating-point reference with 1-LSB tolerance.
module tb_fft_twiddle_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_val, a_ov;
  logic [15:0] a_re, a_im, a_ore, a_oim;
  logic        b_en, b_val, b_ov;
  logic [15:0] b_re, b_im, b_ore, b_oim;

  fft_twiddle_mult #(
    .DATA_WIDTH (16), .TW_WIDTH (16), .N_POINTS (16), .STAGE (0)
  ) u_a (
    .clk (clk), .rst (rst), .en (a_en), .in_val (a_val),
    .in_re (a_re), .in_im (a_im),
    .out_val (a_ov), .out_re (a_ore), .out_im (a_oim)
  );

  fft_twiddle_mult #(
    .DATA_WIDTH (16), .TW_WIDTH (16), .N_POINTS (64), .STAGE (1)
  ) u_b (
    .clk (clk), .rst (rst), .en (b_en), .in_val (b_val),
    .in_re (b_re), .in_im (b_im),
    .out_val (b_ov), .out_re (b_ore), .out_im (b_oim)
  );

  int npass = 0;
  int ntot  = 0;

  // expected-output models: 3-deep latency line per DUT
  int  an;
  bit  mv [3];
  int  mre [3];
  int  mim [3];
  int  bn;
  bit  bv [3];
  real bre [3];
  real bim [3];

  localparam real PI = 3.14159265358979323846;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input int obs, input real exp);
    real ex, diff;
    ex = exp;
    if (ex > 32767.0) ex = 32767.0;
    if (ex < -32768.0) ex = -32768.0;
    diff = real'(obs) - ex;
    if (diff < 0.0) diff = -diff;
    ntot++;
    assert (diff <= 1.0) npass++;
    else $error("FAIL %s observed=%0d expected=%f", tag, obs, ex);
  endtask

  function automatic int tw_exp(input int n, input int m_len);
    int qm;
    int map [4];
    qm = m_len / 4;
    map = '{0, 2, 1, 3};
    return (n % qm) * map[n / qm];
  endfunction

  function automatic int qrnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic void ref_a(input int n, input int a, input int b,
                                output int re, output int im);
    real    th;
    longint c, d, pr, pi_;
    th  = 2.0 * PI * real'(tw_exp(n, 16)) / 16.0;
    c   = longint'(qrnd(16384.0 * $cos(th)));
    d   = longint'(qrnd(-16384.0 * $sin(th)));
    pr  = longint'(a) * c - longint'(b) * d;
    pi_ = longint'(a) * d + longint'(b) * c;
    re  = sat16((pr + 8192) >>> 14);
    im  = sat16((pi_ + 8192) >>> 14);
  endfunction

  task automatic model_reset();
    an = 0;
    bn = 0;
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; mre[i] = 0; mim[i] = 0;
      bv[i] = 0; bre[i] = 0.0; bim[i] = 0.0;
    end
  endtask

  task automatic step_a(input bit en, input bit val, input int re,
                        input int im, input string tag);
    a_en  = en;
    a_val = val;
    a_re  = re[15:0];
    a_im  = im[15:0];
    if (en) begin
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1]; mre[i] = mre[i-1]; mim[i] = mim[i-1];
      end
      mv[0] = val;
      if (val) begin
        ref_a(an, re, im, mre[0], mim[0]);
        an = (an + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".val"}, {15'd0, a_ov}, {15'd0, mv[2]});
    if (mv[2]) begin
      chk({tag, ".re"}, a_ore, mre[2][15:0]);
      chk({tag, ".im"}, a_oim, mim[2][15:0]);
    end
  endtask

  task automatic step_b(input bit val, input int re, input int im);
    real th;
    b_en  = 1'b1;
    b_val = val;
    b_re  = re[15:0];
    b_im  = im[15:0];
    for (int i = 2; i > 0; i--) begin
      bv[i] = bv[i-1]; bre[i] = bre[i-1]; bim[i] = bim[i-1];
    end
    bv[0] = val;
    if (val) begin
      th = 2.0 * PI * real'(tw_exp(bn, 16)) / 16.0;
      bre[0] = real'(re) * $cos(th) + real'(im) * $sin(th);
      bim[0] = real'(im) * $cos(th) - real'(re) * $sin(th);
      bn = (bn + 1) % 16;
    end
    @(posedge clk);
    #1;
    chk("b.val", {15'd0, b_ov}, {15'd0, bv[2]});
    if (bv[2]) begin
      chk_tol("b.re", int'($signed(b_ore)), bre[2]);
      chk_tol("b.im", int'($signed(b_oim)), bim[2]);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    rst = 1'b0;
    a_en = 1'b1; a_val = 1'b0; a_re = '0; a_im = '0;
    b_en = 1'b1; b_val = 1'b0; b_re = '0; b_im = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a.val", {15'd0, a_ov}, 16'd0);
    chk("rst.a.re", a_ore, 16'd0);
    chk("rst.a.im", a_oim, 16'd0);
    chk("rst.b.val", {15'd0, b_ov}, 16'd0);
    rst = 1'b1;

    // frame of 0x1000 with a full-scale corner sample at n=6
    for (int i = 0; i < 16; i++) begin
      if (i == 6) step_a(1, 1, -32768, -32768, "frame1");
      else        step_a(1, 1, 4096, 0, "frame1");
      if (i == 7) begin
        chk("n5.re", a_ore, 16'h0B50);
        chk("n5.im", a_oim, 16'hF4B0);
      end
      if (i == 8) begin
        chk("n6.re", a_ore, 16'h8000);
        chk("n6.im", a_oim, 16'h7FFF);
      end
    end

    // enable held low for 5 cycles mid-frame
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        for (int k = 0; k < 5; k++)
          step_a(0, 1, rnd16(), rnd16(), "stall");
      end
      step_a(1, 1, rnd16(), rnd16(), "frame2");
    end

    // valid on alternate cycles
    for (int i = 0; i < 32; i++)
      step_a(1, (i % 2) == 0, rnd16(), rnd16(), "alt");
    for (int i = 0; i < 3; i++)
      step_a(1, 0, 0, 0, "flush");

    // realign, then reset when the counter reaches 9
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++)
      step_a(1, 1, rnd16(), rnd16(), "pre_rst");
    rst = 1'b0;
    #1;
    chk("midrst.val", {15'd0, a_ov}, 16'd0);
    chk("midrst.re", a_ore, 16'd0);
    chk("midrst.im", a_oim, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_a(1, 1, 32'h1234, 32'h0567, "post_rst");
    for (int i = 0; i < 3; i++) begin
      step_a(1, 1, rnd16(), rnd16(), "post_rst");
      if (i == 1) begin
        chk("w1.re", a_ore, 16'h1234);
        chk("w1.im", a_oim, 16'h0567);
      end
    end
    for (int i = 0; i < 3; i++)
      step_a(1, 0, 0, 0, "flush2");

    // N=64, STAGE=1 random stream vs floating-point reference
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 80; i++)
      step_b($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 16000)) - 8000,
             int'($urandom_range(0, 16000)) - 8000);
    for (int i = 0; i < 3; i++)
      step_b(0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_mult.md
FFT_TWIDDLE_MULT -- requirements
Module: fft_twiddle_mult

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed sample width, real and imaginary.
REQ-002 SHALL have parameter TW_WIDTH, default 16: signed twiddle width, format Q1.(TW_WIDTH-2), +1.0 = 2^(TW_WIDTH-2).
REQ-003 SHALL have parameter N_POINTS, default 16: FFT size, power of 4.
REQ-004 SHALL have parameter STAGE, default 0: index of the radix-2^2 stage whose BF2II output feeds this block.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  global advance; when low, all state holds.
REQ-008 SHALL have port in_val  input  1  input sample valid (BF2II b_val).
REQ-009 SHALL have port in_re  input  DATA_WIDTH  real input, two's complement.
REQ-010 SHALL have port in_im  input  DATA_WIDTH  imaginary input, two's complement.
REQ-011 SHALL have port out_val  output  1  output sample valid.
REQ-012 SHALL have port out_re  output  DATA_WIDTH  real product.
REQ-013 SHALL have port out_im  output  DATA_WIDTH  imaginary product.

Function
REQ-014 SHALL use M = N_POINTS/4^STAGE as sub-transform length; M >= 4 is enforced by an elaboration-time check.
REQ-015 SHALL hold sample counter n (log2 M bits), advancing by 1 only on cycles with en=1 and in_val=1, wrapping M-1 -> 0.
REQ-016 SHALL derive q = n / (M/4) and m = n mod (M/4); exponent e = m*{0,2,1,3}[q]; twiddle W = W_M^e = cos(2*pi*e/M) - j*sin(2*pi*e/M).
REQ-017 SHALL compute out = in * W: re = in_re*c - in_im*d, im = in_re*d + in_im*c, with c = Re(W), d = Im(W).
REQ-018 SHALL use full-precision products/sums (DATA_WIDTH+TW_WIDTH+1 bits), add rounding constant 2^(TW_WIDTH-3), arithmetic-shift right by TW_WIDTH-2.
REQ-019 SHALL saturate each result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 SHALL ensure e = 0 (c = +1.0, d = 0) reproduces input exactly.
REQ-021 SHALL have fixed latency of 3 en-qualified cycles: P1 input/twiddle register, P2 four product registers, P3 add/round/saturate into output registers.
REQ-022 SHALL propagate in_val through a 3-deep valid pipeline; out_val SHALL be asserted exactly with its data.
REQ-023 SHALL let a bubble (en=1, in_val=0) travel as out_val=0, with no counter advance and output data unspecified.
REQ-024 SHALL, when en=0, freeze counter, pipeline, valids, and outputs; no sample lost or duplicated.
REQ-025 SHALL sustain throughput of 1 sample/cycle with no dead cycles at frame wrap.

Reset
REQ-026 SHALL, when rst is low, asynchronously clear n, all pipeline registers, valids; out_val=0, out_re=0, out_im=0.
REQ-027 SHALL, on reset mid-frame, discard in-flight samples; first valid sample after release is treated as n=0.

Structure
REQ-028 SHALL place DATA_WIDTH/TW_WIDTH defaults, the Q-format ONE constant and the {0,2,1,3} quadrant map in shared package fft_pkg.
REQ-029 SHALL put twiddle lookup in one sub-module fft_twiddle_rom (combinational index->{c,d}, 3M/4 entries, values generated at elaboration, rounded to nearest).
REQ-030 SHALL contain no multicycle paths; all state is in the top module.

Verification
REQ-031 SHALL check: N=16, STAGE=0, 16 valid samples of 0x1000+0j -> n=0..4 out 0x1000+0j; n=5 (e=2) out 0x0B50+0xF4B0j, 3 cycles after input.
REQ-032 SHALL check: same stream, n=6 input 0x8000+0x8000j (e=4, W=-j) -> out_re=0x8000, out_im saturated 0x7FFF.
REQ-033 SHALL check: en low 5 cycles mid-frame with valid samples in flight -> outputs/out_val held, sequence resumes with no loss or duplication.
REQ-034 SHALL check: in_val low on alternate cycles -> counter advances only on valid samples; twiddles match REQ-016 per valid index.
REQ-035 SHALL check: rst asserted at n=9 -> outputs 0 immediately, out_val 0; next frame restarts at n=0 with W=1.
REQ-036 SHALL check: N=64, STAGE=1 (M=16) random stream vs. floating-point reference -> |error| <= 1 LSB per component.
